datapath_ctrl: RTL
==================

// Module: datapath_ctrl
// PURPOSE
//  Multi-cycle Moore controller sequencing the 16-bit datapath: register-file read port, A/B operand latches,
//  ALU/shifter, C/status latches and write-back. It sits directly upstream of the register file and A/B latches.
//  It accepts one instruction per start handshake, decodes it and drives readnum/loada/loadb/write/vsel cycle by cycle.
//  It raises w when it is idle and ready for the next instruction.
// PARAMETERS
//  WIDTH     16  datapath word width; sximm8 is sign-extended to this width
//  RN_W      3   register-number width (8 registers)
// PORTS
//  clk       in   1      rising-edge clock
//  reset     in   1      synchronous, active-high reset
//  s         in   1      start; sampled only while w=1
//  instr     in   WIDTH  instruction word; captured into the internal IR when s&&w
//  w         out  1      1 = idle in WAIT; ready to accept s
//  readnum   out  RN_W   register-file read select
//  writenum  out  RN_W   register-file write select
//  write     out  1      register-file write enable
//  loada     out  1      A latch enable
//  loadb     out  1      B latch enable
//  loadc     out  1      C (result) latch enable
//  loads     out  1      status latch enable
//  asel      out  1      1 = ALU A input forced to 0
//  vsel      out  2      write-back source: 00 = C, 10 = sximm8; 01/11 are never driven
//  shift     out  2      IR[4:3], held stable from DECODE until WAIT
//  aluop     out  2      IR[12:11]: 00 ADD, 01 CMP(SUB), 10 AND, 11 MVN
//  sximm8    out  WIDTH  sign-extended IR[7:0]
//  err       out  1      sticky illegal-opcode flag; present only with the macro
// BEHAVIOUR
//  IR fields: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0].
//  Legal instructions:
//   110/10 MOV Rn,#imm8
//   110/00 MOV Rd,Rm,sh
//   101/00 ADD, 101/01 CMP, 101/10 AND, 101/11 MVN
//  States: WAIT, DECODE, GET_A, GET_B, EXEC, WR_REG, WR_IMM. State is registered; outputs are pure functions of state and IR.
//  Sequences (w=0 for every state other than WAIT):
//   MOV imm:      DECODE > WR_IMM > WAIT                  (2 cycles busy)
//   ADD/AND:      DECODE > GET_A > GET_B > EXEC > WR_REG  (5 cycles)
//   CMP:          DECODE > GET_A > GET_B > EXEC           (4 cycles)
//   MOV reg, MVN: DECODE > GET_B > EXEC > WR_REG          (4 cycles)
//  Per-state outputs (all other enables 0):
//   GET_A:  readnum=Rn, loada=1
//   GET_B:  readnum=Rm, loadb=1
//   EXEC:   loadc=1 (ADD/AND/MVN/MOV reg); loads=1 (CMP only); asel=1 for MOV reg
//   WR_REG: writenum=Rd, vsel=00, write=1
//   WR_IMM: writenum=Rn, vsel=10, write=1
//  readnum is 0 outside GET_A/GET_B. write and loada/loadb are never asserted in the same cycle.
//  Handshake:
//   s sampled in WAIT only: WAIT & s -> DECODE, IR<=instr.
//   s while busy is ignored.
//   The last state of each sequence returns to WAIT; s may be accepted in the very next cycle (back-to-back).
//  Reset: state=WAIT, IR=0, w=1, every enable 0, readnum=writenum=0, vsel=00, err=0.
//   Reset mid-sequence abandons the instruction with no further write.
//   Reset takes priority over s.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: an undefined opcode/op seen in DECODE sets err=1 (sticky until reset) and the FSM stays
//   in WAIT with w=0, locked until reset.
//  ILLEGAL_TRAP_EN undefined: err port is absent; an undefined instruction is a NOP, DECODE > WAIT, with no enables.
// STRUCTURE
//  Shared package risc_pkg:
//   state enum ctrl_state_t
//   OPC_MOV=3'b110, OPC_ALU=3'b101
//   ALU op codes
//   VSEL_C=2'b00, VSEL_IMM=2'b10
//   WIDTH default
//  Sub-module instr_dec (combinational): extracts IR fields, legality bit, sximm8.
//  The FSM and output decode live in this module.
// TESTING
//  1. reset, then s=1 with instr=16'hD105 (MOV R1,#5) -> DECODE, then WR_IMM with writenum=1, vsel=10, sximm8=16'h0005,
//     write=1; w=1 on the 3rd cycle after acceptance.
//  2. MOV R2,#-1 (16'hD2FF) -> sximm8=16'hFFFF in WR_IMM.
//  3. ADD R3,R1,R2 (16'hA162) -> GET_A readnum=1 loada; GET_B readnum=2 loadb; EXEC loadc;
//     WR_REG writenum=3 vsel=00 write; 5 busy cycles.
//  4. CMP R1,R2 (16'hA902) -> loads=1 in EXEC, never write; 4 busy cycles. Then back-to-back s on the first w=1 cycle
//     is accepted.
//  5. Assert reset during GET_B of an ADD -> next cycle WAIT, w=1, write never asserted; s held high while busy is ignored.
//  6. instr=16'hE000 -> with ILLEGAL_TRAP_EN: err=1 and w stays 0 until reset; without: returns to WAIT after DECODE,
//     no enables.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit datapath controller: FSM state encoding,
// opcode/op field values, write-back select codes and default widths.
package risc_pkg;

   localparam int WIDTH_DEF = 16;
   localparam int RN_W_DEF  = 3;

   typedef enum logic [2:0] {
      S_WAIT   = 3'd0,
      S_DECODE = 3'd1,
      S_GET_A  = 3'd2,
      S_GET_B  = 3'd3,
      S_EXEC   = 3'd4,
      S_WR_REG = 3'd5,
      S_WR_IMM = 3'd6
   } ctrl_state_t;

   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;

   // op field under OPC_MOV selects immediate vs. register move
   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_MOV_REG = 2'b00;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_CMP = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_MVN = 2'b11;

   localparam logic [1:0] VSEL_C   = 2'b00;
   localparam logic [1:0] VSEL_IMM = 2'b10;

endpackage

// File: rtl/instr_dec.sv
// Combinational instruction decoder: splits the IR into register/shift/op
// fields, classifies the instruction and sign-extends imm8.
module instr_dec
   import risc_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int RN_W  = RN_W_DEF
) (
   input  logic [WIDTH-1:0] ir,
   output logic [RN_W-1:0]  rn,
   output logic [RN_W-1:0]  rd,
   output logic [RN_W-1:0]  rm,
   output logic [1:0]       sh,
   output logic [1:0]       op,
   output logic             legal,
   output logic             is_mov_imm,
   output logic             is_mov_reg,
   output logic             is_cmp,
   output logic             is_mvn,
   output logic [WIDTH-1:0] sximm8
);

   logic [2:0] opcode;
   logic       is_alu;

   function automatic logic signed [WIDTH-1:0] sext8(input logic signed [7:0] v);
      return WIDTH'(v);
   endfunction

   assign opcode = ir[15:13];
   assign op     = ir[12:11];
   assign rn     = RN_W'(ir[10:8]);
   assign rd     = RN_W'(ir[7:5]);
   assign sh     = ir[4:3];
   assign rm     = RN_W'(ir[2:0]);
   assign sximm8 = sext8(ir[7:0]);

   assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
   assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
   assign is_alu     = (opcode == OPC_ALU) && (op inside {ALU_ADD, ALU_CMP, ALU_AND, ALU_MVN});
   assign is_cmp     = is_alu && (op == ALU_CMP);
   assign is_mvn     = is_alu && (op == ALU_MVN);
   assign legal      = is_mov_imm || is_mov_reg || is_alu;

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle Moore controller for the 16-bit datapath: one instruction per
// s&&w handshake. Define ILLEGAL_TRAP_EN to add the sticky err trap/lock.
module datapath_ctrl
   import risc_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int RN_W  = RN_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             s,
   input  logic [WIDTH-1:0] instr,
   output logic             w,
   output logic [RN_W-1:0]  readnum,
   output logic [RN_W-1:0]  writenum,
   output logic             write,
   output logic             loada,
   output logic             loadb,
   output logic             loadc,
   output logic             loads,
   output logic             asel,
   output logic [1:0]       vsel,
   output logic [1:0]       shift,
   output logic [1:0]       aluop,
   output logic [WIDTH-1:0] sximm8
`ifdef ILLEGAL_TRAP_EN
   ,
   output logic             err
`endif
);

   ctrl_state_t      state, state_nxt;
   logic [WIDTH-1:0] ir;
   logic [RN_W-1:0]  rn, rd, rm;
   logic [1:0]       sh, op;
   logic             legal, is_mov_imm, is_mov_reg, is_cmp, is_mvn;
   logic             locked;
   logic             accept;

   instr_dec #(
      .WIDTH (WIDTH),
      .RN_W  (RN_W)
   ) u_dec (
      .ir         (ir),
      .rn         (rn),
      .rd         (rd),
      .rm         (rm),
      .sh         (sh),
      .op         (op),
      .legal      (legal),
      .is_mov_imm (is_mov_imm),
      .is_mov_reg (is_mov_reg),
      .is_cmp     (is_cmp),
      .is_mvn     (is_mvn),
      .sximm8     (sximm8)
   );

`ifdef ILLEGAL_TRAP_EN
   logic err_q;
   logic err_set;

   assign err_set = (state == S_DECODE) && !legal;
   assign locked  = err_q;
   assign err     = err_q;

   always_ff @(posedge clk) begin
      if (reset)
         err_q <= 1'b0;
      else if (err_set)
         err_q <= 1'b1;
   end
`else
   assign locked = 1'b0;
`endif

   assign accept = (state == S_WAIT) && !locked && s;

   // IR only moves on acceptance, so shift/aluop/sximm8 stay stable while busy
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_WAIT;
         ir    <= '0;
      end else begin
         state <= state_nxt;
         if (accept)
            ir <= instr;
      end
   end

   assign shift = sh;
   assign aluop = op;

   always_comb begin
      state_nxt = state;
      w         = 1'b0;
      readnum   = '0;
      writenum  = '0;
      write     = 1'b0;
      loada     = 1'b0;
      loadb     = 1'b0;
      loadc     = 1'b0;
      loads     = 1'b0;
      asel      = 1'b0;
      vsel      = VSEL_C;

      case (state)
         S_WAIT: begin
            w = !locked;
            if (accept)
               state_nxt = S_DECODE;
         end
         S_DECODE: begin
            // illegal words drop back to WAIT; with the trap the lock holds w low there
            if (!legal)
               state_nxt = S_WAIT;
            else if (is_mov_imm)
               state_nxt = S_WR_IMM;
            else if (is_mov_reg || is_mvn)
               state_nxt = S_GET_B;
            else
               state_nxt = S_GET_A;
         end
         S_GET_A: begin
            readnum   = rn;
            loada     = 1'b1;
            state_nxt = S_GET_B;
         end
         S_GET_B: begin
            readnum   = rm;
            loadb     = 1'b1;
            state_nxt = S_EXEC;
         end
         S_EXEC: begin
            loadc     = !is_cmp;
            loads     = is_cmp;
            asel      = is_mov_reg;
            state_nxt = is_cmp ? S_WAIT : S_WR_REG;
         end
         S_WR_REG: begin
            writenum  = rd;
            vsel      = VSEL_C;
            write     = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WR_IMM: begin
            writenum  = rn;
            vsel      = VSEL_IMM;
            write     = 1'b1;
            state_nxt = S_WAIT;
         end
         default: state_nxt = S_WAIT;
      endcase
   end

endmodule
